pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic parametrised inter-stage pipeline register that supersedes the fixed per-stage registers. It carries an opaque payload of DATA_W bits with a valid/ready handshake and an optional 2-entry skid buffer. It supports flush (bubble) and hazard stall, and loads a configurable NOP payload on flush or when empty. It is instantiated between any two pipeline stages (F/D, D/E, E/M, M/W); the stage packs its fields into the payload.

Parameters:
DATA_W, 64, payload width in bits (>=1).
NOP_VALUE, {DATA_W{1'b0}}, payload presented on reset, on flush and while empty.
SKID, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single entry with combinational ready pass-through.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush_i  input  1  bubble: discard all held entries
stall_i  input  1  hazard stall: freeze contents, no accept, no emit
in_valid_i  input  1  upstream payload valid
in_ready_o  output  1  block can accept this cycle
in_data_i  input  DATA_W  upstream payload
out_valid_o  output  1  head entry valid to downstream
out_ready_i  input  1  downstream accepts head
out_data_o  output  DATA_W  head payload (NOP_VALUE when no valid entry)
count_o  output  2  occupancy 0..2 (0..1 when SKID=0)

Behaviour:
- Storage: main register (head, drives out_data_o), plus skid register when SKID=1. Each register has a valid flag. count_o = main_v + skid_v, registered.
- push = in_valid_i & in_ready_o. pop = out_valid_o & out_ready_i. Both are evaluated in the same cycle.
- out_valid_o = main_v & ~stall_i.
- SKID=1: in_ready_o = ~skid_v & ~stall_i & ~flush_i. It depends only on flops and stall/flush, with no path from out_ready_i.
- SKID=0: in_ready_o = (~main_v | out_ready_i) & ~stall_i & ~flush_i.
- Priority, highest first: rst, flush_i, stall_i, normal operation.
- rst or flush_i: next cycle main_v=0, skid_v=0, both data registers = NOP_VALUE, count_o=0, out_valid_o=0. Any concurrent push or pop is ignored, and upstream must not treat the beat as accepted (in_ready_o is already 0 on flush). Reset applies mid-transfer identically.
- stall_i (no flush): all registers hold. in_ready_o=0 and out_valid_o=0, so no transfer occurs.
- State machine (SKID=1), state = count:
  - EMPTY (0): push -> ONE, main=in_data_i.
  - ONE (1): push&pop -> ONE, main=in_data_i. push only -> FULL, skid=in_data_i, main held. pop only -> EMPTY, main=NOP_VALUE. Neither -> hold.
  - FULL (2): in_ready_o=0. pop -> ONE, main=skid, skid=NOP_VALUE. No pop -> hold.
- SKID=0: EMPTY/ONE only. Push with simultaneous pop replaces main (full-throughput pass). Pop only -> EMPTY with main=NOP_VALUE.
- Latency: a pushed payload appears on out_data_o with out_valid_o=1 exactly one cycle after the push when the block was EMPTY, or when it was ONE with a simultaneous pop.
- Throughput: 1 beat/cycle sustained when out_ready_i=1 in both modes.
- Ordering: strict FIFO. No payload is duplicated or lost except through flush or reset.
- While out_valid_o=1 and not popped, out_data_o is stable (held across stall and backpressure).
- Invalid-entry data is always NOP_VALUE, never stale, so downstream sees a NOP on out_data_o without qualifying by valid.

Test Plan:
- Reset, then stream with DATA_W=64, SKID=1, in_valid_i=1, out_ready_i=1, payloads 1,2,3,4 on consecutive cycles -> out_data_o shows 1,2,3,4 one cycle later on consecutive cycles, count_o=1 throughout, in_ready_o=1 throughout.
- Backpressure: load 0xA, hold out_ready_i=0, push 0xB -> count_o=2, in_ready_o=0, out_data_o=0xA stable. Release out_ready_i -> 0xA pops, then 0xB, then count_o=0 and out_data_o=NOP_VALUE.
- Flush while FULL with a simultaneous push of 0xC -> next cycle count_o=0, out_valid_o=0, out_data_o=NOP_VALUE. 0xC never appears on the output.
- Stall for 3 cycles with main=0x5 and in_valid_i=1 -> in_ready_o=0, out_valid_o=0, out_data_o=0x5 held. After stall drops, 0x5 pops first, then the pending input.
- SKID=0, NOP_VALUE=0x13: push 7 with out_ready_i=1 every cycle -> 1 beat/cycle. With out_ready_i=0, in_ready_o=0 while count_o=1. Pop with no push -> out_data_o=0x13.
- rst asserted during a push&pop cycle from ONE -> next cycle all outputs at reset values (count_o=0, out_valid_o=0, out_data_o=NOP_VALUE).

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: valid/ready handshake, optional
// 2-entry skid buffer, flush/stall control and NOP payload when empty.
//
// state | meaning
// EMPTY | no valid entry, out_data_o = NOP_VALUE
// ONE   | main register valid (head)
// FULL  | main and skid registers valid (SKID=1 only)
module pipe_stage_reg #(
   parameter int                DATA_W    = 64,
   parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
   parameter int                SKID      = 1
) (
   input  logic              clk_i,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              stall_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        count_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              main_v, skid_v;
   logic              push, pop;

   // Encoding equals occupancy, so count_o comes straight from the state flop.
   assign main_v  = (state_q != EMPTY);
   assign skid_v  = (state_q == FULL);
   assign count_o = state_q;

   assign out_valid_o = main_v & ~stall_i;
   assign out_data_o  = main_q;
   assign in_ready_o  = ((SKID != 0) ? ~skid_v : (~main_v | out_ready_i))
                        & ~stall_i & ~flush_i;

   assign push = in_valid_i & in_ready_o;
   assign pop  = out_valid_o & out_ready_i;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = EMPTY;
         main_d  = NOP_VALUE;
         skid_d  = NOP_VALUE;
      end else begin
         // push/pop are both forced low by stall, so stall falls through as hold
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_d = ONE;
                  main_d  = in_data_i;
               end
            end
            ONE: begin
               if (push && pop) begin
                  main_d = in_data_i;
               end else if (push && (SKID != 0)) begin
                  state_d = FULL;
                  skid_d  = in_data_i;
               end else if (pop) begin
                  state_d = EMPTY;
                  main_d  = NOP_VALUE;
               end
            end
            FULL: begin
               if (pop) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  skid_d  = NOP_VALUE;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = NOP_VALUE;
               skid_d  = NOP_VALUE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= NOP_VALUE;
         skid_q  <= NOP_VALUE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share stimulus and
// are each compared every cycle against a queue-based occupancy model.
module tb_pipe_stage_reg;

   localparam int          DW   = 64;
   localparam logic [63:0] NOP1 = 64'h0;
   localparam logic [63:0] NOP0 = 64'h13;

   logic          clk_i = 1'b0;
   logic          rst, flush_i, stall_i, in_valid_i, out_ready_i;
   logic [DW-1:0] in_data_i;
   logic          in_ready1, out_valid1, in_ready0, out_valid0;
   logic [DW-1:0] out_data1, out_data0;
   logic [1:0]    count1, count0;

   int n_checks = 0;
   int n_err    = 0;

   logic [DW-1:0] q1[$];
   logic [DW-1:0] q0[$];

   always #5 clk_i = ~clk_i;

   pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP1), .SKID(1)) dut1 (
      .clk_i(clk_i), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready1), .in_data_i(in_data_i),
      .out_valid_o(out_valid1), .out_ready_i(out_ready_i),
      .out_data_o(out_data1), .count_o(count1));

   pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP0), .SKID(0)) dut0 (
      .clk_i(clk_i), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready0), .in_data_i(in_data_i),
      .out_valid_o(out_valid0), .out_ready_i(out_ready_i),
      .out_data_o(out_data0), .count_o(count0));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: check outputs mid-cycle against the model, then advance the model at the edge.
   task automatic step();
      int          sz1, sz0;
      logic        er1, er0, ev1, ev0;
      logic [63:0] ed1, ed0;
      @(negedge clk_i);
      sz1 = q1.size();
      sz0 = q0.size();
      er1 = (sz1 < 2) && !stall_i && !flush_i;
      er0 = (sz0 == 0 || out_ready_i) && !stall_i && !flush_i;
      ev1 = (sz1 > 0) && !stall_i;
      ev0 = (sz0 > 0) && !stall_i;
      ed1 = (sz1 > 0) ? q1[0] : NOP1;
      ed0 = (sz0 > 0) ? q0[0] : NOP0;
      chk("skid_in_ready",  64'(in_ready1),  64'(er1));
      chk("skid_out_valid", 64'(out_valid1), 64'(ev1));
      chk("skid_out_data",  out_data1,       ed1);
      chk("skid_count",     64'(count1),     64'(sz1));
      chk("pass_in_ready",  64'(in_ready0),  64'(er0));
      chk("pass_out_valid", 64'(out_valid0), 64'(ev0));
      chk("pass_out_data",  out_data0,       ed0);
      chk("pass_count",     64'(count0),     64'(sz0));
      @(posedge clk_i);
      if (rst || flush_i) begin
         q1.delete();
         q0.delete();
      end else if (!stall_i) begin
         if (ev1 && out_ready_i) void'(q1.pop_front());
         if (in_valid_i && er1)  q1.push_back(in_data_i);
         if (ev0 && out_ready_i) void'(q0.pop_front());
         if (in_valid_i && er0)  q0.push_back(in_data_i);
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
      in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = '0;
      @(posedge clk_i); #1;
      step();
      rst = 1'b0;
      step();

      // streaming at full rate
      in_valid_i = 1'b1; out_ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_data_i = 64'(i);
         step();
      end
      in_valid_i = 1'b0;
      step(); step();

      // backpressure: fill skid, hold, then drain
      out_ready_i = 1'b0; in_valid_i = 1'b1;
      in_data_i = 64'hA; step();
      in_data_i = 64'hB; step();
      in_valid_i = 1'b0; step(); step();
      out_ready_i = 1'b1; step(); step(); step();

      // flush while full with a concurrent push
      out_ready_i = 1'b0; in_valid_i = 1'b1;
      in_data_i = 64'hD; step();
      in_data_i = 64'hE; step();
      flush_i = 1'b1; in_data_i = 64'hC; step();
      flush_i = 1'b0; in_valid_i = 1'b0; step();
      out_ready_i = 1'b1; step();

      // stall with a pending input
      out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 64'h5; step();
      in_data_i = 64'h6; stall_i = 1'b1;
      step(); step(); step();
      stall_i = 1'b0; out_ready_i = 1'b1; step();
      in_valid_i = 1'b0; step(); step(); step();

      // seven back-to-back beats, then backpressure and NOP after drain
      in_valid_i = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_data_i = 64'h70 + 64'(i);
         step();
      end
      out_ready_i = 1'b0; in_data_i = 64'h99; step(); step();
      in_valid_i = 1'b0; out_ready_i = 1'b1; step(); step(); step();

      // reset during push&pop from ONE
      out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 64'h21; step();
      out_ready_i = 1'b1; in_data_i = 64'h22; rst = 1'b1; step();
      rst = 1'b0; in_valid_i = 1'b0; step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid_i  = ($urandom_range(0, 3) != 0);
         out_ready_i = ($urandom_range(0, 2) != 0);
         stall_i     = ($urandom_range(0, 7) == 0);
         flush_i     = ($urandom_range(0, 15) == 0);
         rst         = ($urandom_range(0, 63) == 0);
         in_data_i   = {$urandom, $urandom};
         step();
      end
      rst = 1'b0; flush_i = 1'b0; stall_i = 1'b0; in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      step(); step(); step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
